hazard_scoreboard: RTL

- Parametrised issue-hazard unit for the multi-lane in-order pipeline. It replaces the fixed two-lane load-use stall check.
- Keeps a per-register countdown scoreboard of in-flight results with variable latency: loads, multiply/divide and ALU ops.
- Decides each cycle which prefix of the decode bundle may issue. Sits between decode and the register-read/execute stage.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/hazard_scoreboard_if.sv | 25 ++
 rtl/hazard_lane_check.sv | 37 +++
 rtl/hazard_scoreboard.sv | 129 ++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the issue-hazard scoreboard: nominal unit latencies and the zero register.
package hazard_pkg;

    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;
    localparam int LAT_MUL  = 4;
    localparam int LAT_DIV  = 7;
    localparam int ZERO_REG = 0;

    // Counter value loaded at issue: result usable after lat cycles, lat 0 behaves like 1.
    function automatic int lat_to_cnt(input int lat);
        return (lat > 0) ? lat - 1 : 0;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-to-scoreboard bundle: per-lane instruction fields in, issue decision out.
interface hazard_scoreboard_if #(
    parameter int LANES = 2,
    parameter int AW    = 5,
    parameter int CW    = 3
);
    logic [LANES-1:0]    dec_valid;
    logic [LANES*AW-1:0] dec_rs1;
    logic [LANES*AW-1:0] dec_rs2;
    logic [LANES*AW-1:0] dec_rd;
    logic [LANES-1:0]    dec_wen;
    logic [LANES*CW-1:0] dec_lat;
    logic [LANES-1:0]    issue_mask;
    logic                stall;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_wen, dec_lat,
        input  issue_mask, stall
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_wen, dec_lat,
        output issue_mask, stall
    );
endinterface

// File: rtl/hazard_lane_check.sv
// Combinational hazard test for one decode lane: scoreboard sources plus older in-bundle writers.
module hazard_lane_check
    import hazard_pkg::*;
#(
    parameter int LANES = 2,
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int LANE  = 0
) (
    input  logic [LANES-1:0]    valid_i,
    input  logic [LANES-1:0]    wen_i,
    input  logic [LANES*AW-1:0] rd_i,
    input  logic [AW-1:0]       rs1_i,
    input  logic [AW-1:0]       rs2_i,
    input  logic [NREGS-1:0]    busy_i,
    output logic                hazard_o
);
    logic          src_haz;
    logic          intra_haz;
    logic [AW-1:0] rd_l;

    always_comb begin
        // busy_i[0] is tied low, so reading r0 never registers as a hazard
        src_haz   = busy_i[rs1_i] | busy_i[rs2_i];
        intra_haz = 1'b0;
        rd_l      = '0;
        for (int i = 0; i < LANES; i++) begin
            rd_l = rd_i[i*AW +: AW];
            if (i < LANE && valid_i[i] && wen_i[i] && rd_l != AW'(ZERO_REG) &&
                (rd_l == rs1_i || rd_l == rs2_i)) begin
                intra_haz = 1'b1;
            end
        end
        hazard_o = valid_i[LANE] & (src_haz | intra_haz);
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Multi-lane in-order issue hazard unit with per-register latency countdown.
// Optional HAZARD_STATS_EN adds stall_cycles / split_cycles performance counters.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int LANES = 2,
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int CW    = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic                hold,
    hazard_scoreboard_if.slave  dec,
    output logic                sb_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]         stall_cycles,
    output logic [31:0]         split_cycles
`endif
);
    logic [NREGS-1:0] busy_vec;
    logic [NREGS-1:0] nz_next;
    logic [LANES-1:0] hazard;
    logic [LANES-1:0] blocked;
    logic [LANES-1:0] issue;
    logic             squash;
    logic             stall;
    logic             sb_busy_q;

    assign busy_vec[0] = 1'b0;
    assign nz_next[0]  = 1'b0;
    assign squash      = reset | flush;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        hazard_lane_check #(
            .LANES (LANES),
            .NREGS (NREGS),
            .AW    (AW),
            .LANE  (gi)
        ) u_chk (
            .valid_i  (dec.dec_valid),
            .wen_i    (dec.dec_wen),
            .rd_i     (dec.dec_rd),
            .rs1_i    (dec.dec_rs1[gi*AW +: AW]),
            .rs2_i    (dec.dec_rs2[gi*AW +: AW]),
            .busy_i   (busy_vec),
            .hazard_o (hazard[gi])
        );

        // Once a lane blocks, every younger lane is blocked too (in-order prefix)
        if (gi == 0) begin : g_first
            assign blocked[gi] = hold | hazard[gi];
        end else begin : g_rest
            assign blocked[gi] = blocked[gi-1] | hazard[gi];
        end
    end

    assign issue          = squash ? '0 : (dec.dec_valid & ~blocked);
    assign stall          = ~squash & (|(dec.dec_valid & blocked));
    assign dec.issue_mask = issue;
    assign dec.stall      = stall;

    for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;

        always_comb begin
            cnt_d = (cnt_q != '0) ? cnt_q - CW'(1) : '0;
            // Ascending lane order lets the youngest issuing writer win
            for (int l = 0; l < LANES; l++) begin
                if (issue[l] && dec.dec_wen[l] && dec.dec_rd[l*AW +: AW] == AW'(gi)) begin
                    cnt_d = CW'(lat_to_cnt(int'(dec.dec_lat[l*CW +: CW])));
                end
            end
            if (hold) begin
                cnt_d = cnt_q;
            end
            if (flush) begin
                cnt_d = '0;
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign busy_vec[gi] = |cnt_q;
        assign nz_next[gi]  = |cnt_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sb_busy_q <= 1'b0;
        end else begin
            sb_busy_q <= |nz_next;
        end
    end

    assign sb_busy = sb_busy_q;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] split_cycles_q;

    // Flush deliberately leaves these running totals intact
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles_q <= '0;
            split_cycles_q <= '0;
        end else if (stall) begin
            if (issue == '0) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end else begin
                split_cycles_q <= split_cycles_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign split_cycles = split_cycles_q;
`endif

endmodule
